// File: rtl/i2c_slave_pkg.sv
// Shared types for the I2C slave responder: FSM states and bus events.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    typedef struct packed {
        logic start;
        logic stop;
        logic scl_rise;
        logic scl_fall;
    } bus_evt_t;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Bus-side and register-strobe signals of the I2C slave responder.
interface i2c_slave_responder_if #(
    parameter int unsigned NUM_REGS = 16
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic          scl_i;
    logic          sda_i;
    logic          sda_oe_o;
    logic          wr_strb_o;
    logic [AW-1:0] wr_addr_o;
    logic [7:0]    wr_data_o;
    logic          rd_strb_o;
    logic          busy_o;

    modport slave (
        input  scl_i, sda_i,
        output sda_oe_o, wr_strb_o, wr_addr_o, wr_data_o, rd_strb_o, busy_o
    );

    modport master (
        output scl_i, sda_i,
        input  sda_oe_o, wr_strb_o, wr_addr_o, wr_data_o, rd_strb_o, busy_o
    );
endinterface

// File: rtl/i2c_slave_sync_edge.sv
// Synchronizes SCL/SDA and derives SCL edges plus START/STOP conditions.
module i2c_slave_sync_edge
    import i2c_slave_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  logic     scl_i,
    input  logic     sda_i,
    output logic     sda_s_o,
    output bus_evt_t evt_o
);
    logic scl_meta_q, scl_sync_q, scl_hist_q;
    logic sda_meta_q, sda_sync_q, sda_hist_q;
    logic scl_meta_d, scl_sync_d, scl_hist_d;
    logic sda_meta_d, sda_sync_d, sda_hist_d;

    // Next values: two-stage synchronizer followed by one history stage.
    always_comb begin
        scl_meta_d = scl_i;
        scl_sync_d = scl_meta_q;
        scl_hist_d = scl_sync_q;
        sda_meta_d = sda_i;
        sda_sync_d = sda_meta_q;
        sda_hist_d = sda_sync_q;
    end

    // Synchronizer and history flops; idle bus level is high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    // Event decode from synchronized value versus history.
    always_comb begin
        evt_o.scl_rise = scl_sync_q & ~scl_hist_q;
        evt_o.scl_fall = ~scl_sync_q & scl_hist_q;
        evt_o.start    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
        evt_o.stop     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
        sda_s_o        = sda_sync_q;
    end
endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave with an internal register file addressed by an auto-incrementing pointer.
module i2c_slave_responder
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h22,
    parameter int unsigned NUM_REGS   = 16
)(
    input  logic clk_i,
    input  logic rst_n_i,
    i2c_slave_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    bus_evt_t evt;
    logic     sda_s;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    tx_q, tx_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          ack_q, ack_d;
    logic          sda_oe_q, sda_oe_d;
    logic          wr_strb_q, wr_strb_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          rd_strb_q, rd_strb_d;
    logic          busy_q, busy_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];
    logic [AW-1:0] ptr_inc;

    i2c_slave_sync_edge u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .scl_i   (bus.scl_i),
        .sda_i   (bus.sda_i),
        .sda_s_o (sda_s),
        .evt_o   (evt)
    );

    assign ptr_inc = ptr_q + 1'b1;

    // Next-state and output logic; STOP beats START beats SCL edges.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        ack_d     = ack_q;
        sda_oe_d  = sda_oe_q;
        wr_strb_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_strb_d = 1'b0;
        busy_d    = busy_q;
        regs_d    = regs_q;

        if (evt.stop) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (evt.start) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (evt.scl_rise) begin
            unique case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (cnt_q < 4'd8) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                ST_RDATA: begin
                    if (cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
                end
                ST_RDATA_ACK: ack_d = sda_s;
                default: ;
            endcase
        end else if (evt.scl_fall) begin
            unique case (state_q)
                ST_ADDR: begin
                    if (cnt_q == 4'd8) begin
                        if (shreg_q[7:1] == SLAVE_ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d  = ST_IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    cnt_d = '0;
                    if (shreg_q[0]) begin
                        state_d   = ST_RDATA;
                        tx_d      = regs_q[ptr_q];
                        rd_strb_d = 1'b1;
                        sda_oe_d  = ~regs_q[ptr_q][7];
                    end else begin
                        state_d  = ST_PTR;
                        sda_oe_d = 1'b0;
                    end
                end
                ST_PTR: begin
                    if (cnt_q == 4'd8) begin
                        ptr_d    = shreg_q[AW-1:0];
                        sda_oe_d = 1'b1;
                        state_d  = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    sda_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_WDATA;
                end
                ST_WDATA: begin
                    if (cnt_q == 4'd8) begin
                        regs_d[ptr_q] = shreg_q;
                        wr_strb_d     = 1'b1;
                        wr_addr_d     = ptr_q;
                        wr_data_d     = shreg_q;
                        ptr_d         = ptr_inc;
                        sda_oe_d      = 1'b1;
                        state_d       = ST_WDATA_ACK;
                    end
                end
                ST_RDATA: begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_RDATA_ACK;
                    end else begin
                        sda_oe_d = ~tx_q[3'd7 - cnt_q[2:0]];
                    end
                end
                ST_RDATA_ACK: begin
                    if (!ack_q) begin
                        ptr_d     = ptr_inc;
                        tx_d      = regs_q[ptr_inc];
                        rd_strb_d = 1'b1;
                        sda_oe_d  = ~regs_q[ptr_inc][7];
                        cnt_d     = '0;
                        state_d   = ST_RDATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, datapath and register-file flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            ack_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            wr_strb_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_strb_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            sda_oe_q  <= sda_oe_d;
            wr_strb_q <= wr_strb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_strb_q <= rd_strb_d;
            busy_q    <= busy_d;
            regs_q    <= regs_d;
        end
    end

    assign bus.sda_oe_o  = sda_oe_q;
    assign bus.wr_strb_o = wr_strb_q;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;
    assign bus.rd_strb_o = rd_strb_q;
    assign bus.busy_o    = busy_q;
endmodule
